conv_sequencer: RTL and testbench

Time-multiplexed controller for the 3×3 RGB image convolution. It walks every output pixel of a 3-channel H×V frame held in an external synchronous RAM, issues one read per in-range kernel tap, and accumulates with a single shared MAC. It clamps each result to 0..255 and writes it to a result RAM. It replaces the fully unrolled combinational convolver when frame size makes a per-pixel parallel array infeasible, and sits between the frame-buffer RAMs and the host/config logic.

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_mac.sv | 30 +++
 rtl/conv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_conv_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the time-multiplexed 3x3 RGB convolution sequencer.
package conv_pkg;

  localparam int ACC_W = 20;
  localparam int TAPS  = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAP,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } conv_state_t;

  typedef struct packed {
    logic signed [1:0] m;
    logic signed [1:0] n;
  } tap_off_t;

  // Row-major tap index to (row, column) offset in -1..1.
  function automatic tap_off_t tap_offset(input logic [3:0] t);
    tap_off_t r;
    if (t < 4'd3)      r.m = -2'sd1;
    else if (t < 4'd6) r.m = 2'sd0;
    else               r.m = 2'sd1;
    case (t)
      4'd0, 4'd3, 4'd6: r.n = -2'sd1;
      4'd1, 4'd4, 4'd7: r.n = 2'sd0;
      default:          r.n = 2'sd1;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] clamp_u8(input logic signed [ACC_W-1:0] acc);
    if (acc[ACC_W-1])       return 8'd0;
    else if (acc > 20'sd255) return 8'd255;
    else                    return acc[7:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Shared multiply-accumulate: unsigned pixel times signed coefficient into a 20-bit accumulator.
module conv_mac
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [7:0]        i_data,
  input  logic signed [7:0] i_coef,
  output logic [7:0]        o_result
);

  logic signed [16:0]      w_prod;
  logic signed [ACC_W-1:0] w_acc_nx;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod   = 17'($signed({1'b0, i_data})) * 17'(i_coef);
  assign w_acc_nx = i_en ? r_acc + ACC_W'(w_prod) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else            r_acc <= w_acc_nx;
  end

  // Clamp the look-ahead sum so the final tap is included when the result is captured.
  assign o_result = clamp_u8(w_acc_nx);

endmodule

// File: rtl/conv_sequencer.sv
// Walks every output pixel of a 3-channel HxV frame, one tap per cycle, into a shared MAC.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int H      = 8,
  parameter int V      = 8,
  parameter int ADDR_W = $clog2(3*H*V)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              k_we,
  input  logic [3:0]        k_addr,
  input  logic signed [7:0] k_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int IW = (H > 1) ? $clog2(H) : 1;
  localparam int JW = (V > 1) ? $clog2(V) : 1;

  conv_state_t       r_state, w_state_nx;
  logic [1:0]        r_ch, w_ch_nx;
  logic [IW-1:0]     r_i, w_i_nx;
  logic [JW-1:0]     r_j, w_j_nx;
  logic [3:0]        r_t, w_t_nx;
  logic signed [7:0] r_kernel [TAPS];
  logic signed [7:0] r_coef;
  logic              r_mac_en;
  logic              r_rd_en, r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        w_mac_result;
  tap_off_t          w_off;
  int                w_row, w_col;
  logic              w_rd_go;
  logic [ADDR_W-1:0] w_rd_addr, w_pix_addr;
  logic              w_last_pix;

  assign w_last_pix = (r_ch == 2'd2) && (r_i == IW'(H-1)) && (r_j == JW'(V-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ch    <= w_ch_nx;
      r_i     <= w_i_nx;
      r_j     <= w_j_nx;
      r_t     <= w_t_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ch_nx    = r_ch;
    w_i_nx     = r_i;
    w_j_nx     = r_j;
    w_t_nx     = r_t;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nx = S_TAP;
        w_ch_nx    = '0;
        w_i_nx     = '0;
        w_j_nx     = '0;
        w_t_nx     = '0;
      end
      S_TAP: begin
        if (r_t == 4'd8) begin
          w_state_nx = S_DRAIN;
          w_t_nx     = '0;
        end else begin
          w_t_nx = r_t + 4'd1;
        end
      end
      S_DRAIN: w_state_nx = S_WRITE;
      S_WRITE: begin
        if (w_last_pix) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_TAP;
          if (r_j == JW'(V-1)) begin
            w_j_nx = '0;
            if (r_i == IW'(H-1)) begin
              w_i_nx  = '0;
              w_ch_nx = r_ch + 2'd1;
            end else begin
              w_i_nx = r_i + IW'(1);
            end
          end else begin
            w_j_nx = r_j + JW'(1);
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Read strobe/address are computed from next-cycle counters so the registered copy lines up with its tap.
  always_comb begin
    w_off     = tap_offset(w_t_nx);
    w_row     = int'(w_i_nx) + int'(w_off.m);
    w_col     = int'(w_j_nx) + int'(w_off.n);
    w_rd_go   = (w_state_nx == S_TAP) && (w_row >= 0) && (w_row < H) && (w_col >= 0) && (w_col < V);
    w_rd_addr = ADDR_W'(int'(w_ch_nx) * H * V + w_row * V + w_col);
    w_pix_addr = ADDR_W'(int'(r_ch) * H * V + int'(r_i) * V + int'(r_j));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_kernel[k] <= '0;
    end else if (k_we && (k_addr <= 4'd8) && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
      r_kernel[k_addr] <= k_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_mac_en  <= 1'b0;
      r_coef    <= '0;
    end else begin
      r_rd_en   <= w_rd_go;
      r_rd_addr <= w_rd_go ? w_rd_addr : '0;
      r_wr_en   <= (r_state == S_DRAIN);
      r_wr_addr <= (r_state == S_DRAIN) ? w_pix_addr : '0;
      r_wr_data <= (r_state == S_DRAIN) ? w_mac_result : '0;
      r_mac_en  <= r_rd_en;
      r_coef    <= r_kernel[r_t];
    end
  end

  conv_mac u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    ((r_state == S_IDLE) || (r_state == S_WRITE)),
    .i_en     (r_mac_en),
    .i_data   (rd_data),
    .i_coef   (r_coef),
    .o_result (w_mac_result)
  );

  assign busy    = (r_state == S_TAP) || (r_state == S_DRAIN) || (r_state == S_WRITE);
  assign done    = (r_state == S_DONE);
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer on a 4x4 RGB frame with a behavioural source RAM.
module tb_conv_sequencer;

  localparam int H  = 4;
  localparam int V  = 4;
  localparam int AW = $clog2(3*H*V);
  localparam int RUN_DONE = 1 + 33*H*V;

  logic              clk, rst_n;
  logic              k_we;
  logic [3:0]        k_addr;
  logic signed [7:0] k_data;
  logic              start, busy, done;
  logic              rd_en, wr_en;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [7:0]        rd_data, wr_data;

  logic [7:0]  src [64];
  int          k_model [9];
  logic [17:0] exp_q [$];
  int          rd_cnt;
  int          n_tests, n_fail;

  conv_sequencer #(.H(H), .V(V)) dut (
    .clk(clk), .rst_n(rst_n), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
    .start(start), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // clock / source RAM
  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: pops one entry per result write
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      rd_cnt = 0;
    end else begin
      if (rd_en) rd_cnt++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[13:8]));
          check("wr_data", 32'(wr_data), 32'(e[7:0]));
          check("rd_count", rd_cnt, 32'(e[17:14]));
        end
        rd_cnt = 0;
      end
    end
  end

  task automatic push_expected();
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < H; i++)
        for (int j = 0; j < V; j++) begin
          int acc, cnt, r, c, v;
          acc = 0;
          cnt = 0;
          for (int t = 0; t < 9; t++) begin
            r = i + t / 3 - 1;
            c = j + t % 3 - 1;
            if (r >= 0 && r < H && c >= 0 && c < V) begin
              acc += int'(src[ch*H*V + r*V + c]) * k_model[t];
              cnt++;
            end
          end
          v = (acc < 0) ? 0 : (acc > 255) ? 255 : acc;
          exp_q.push_back({4'(cnt), 6'(ch*H*V + i*V + j), 8'(v)});
        end
  endtask

  // driver tasks
  task automatic write_k(input logic [3:0] a, input int d);
    @(negedge clk);
    k_we   = 1'b1;
    k_addr = a;
    k_data = 8'(d);
    @(negedge clk);
    k_we = 1'b0;
    if (a <= 4'd8) k_model[a] = d;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
  endtask

  task automatic run_frame(input bit hold, input int rst_at, input bit kwe_busy,
                           input bit kwe_start, input logic [3:0] ka, input int kd);
    bit seen, aborted;
    seen    = 0;
    aborted = 0;
    @(negedge clk);
    if (kwe_start) begin
      k_we   = 1'b1;
      k_addr = ka;
      k_data = 8'(kd);
      if (ka <= 4'd8) k_model[ka] = kd;
    end
    push_expected();
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= RUN_DONE + 60 && !seen && !aborted; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        k_we = 1'b0;
        if (!hold) start = 1'b0;
        check("busy_first_cycle", 32'(busy), 1);
      end
      if (kwe_busy && cyc == 50) begin
        k_we   = 1'b1;
        k_addr = 4'd3;
        k_data = 8'sd77;
      end
      if (kwe_busy && cyc == 51) k_we = 1'b0;
      if (cyc == rst_at) begin
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid");
        start = 1'b0;
        exp_q.delete();
        for (int t = 0; t < 9; t++) k_model[t] = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        aborted = 1;
      end else if (done) begin
        seen = 1;
        check("done_cycle", cyc, RUN_DONE);
        check("busy_at_done", 32'(busy), 0);
      end
    end
    if (!seen && !aborted) check("done_timeout", 0, 1);
    if (hold && seen) begin
      @(negedge clk);
      check("hold_idle_busy", 32'(busy), 0);
      check("hold_idle_rd_en", 32'(rd_en), 0);
      start = 1'b0;
      @(negedge clk);
      check("hold_no_restart", 32'(busy), 0);
    end
    if (!aborted) check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic load_kernel_all(input int v, input int centre);
    for (int t = 0; t < 9; t++) write_k(4'(t), (t == 4) ? centre : v);
  endtask

  initial begin
    clk = 0; rst_n = 0; start = 0; k_we = 0; k_addr = 0; k_data = 0;
    n_tests = 0; n_fail = 0; rd_cnt = 0;
    for (int t = 0; t < 9; t++) k_model[t] = 0;
    for (int a = 0; a < 64; a++) src[a] = 8'(a);
    #3 check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // identity kernel, ramp source
    write_k(4'd4, 1);
    run_frame(0, 0, 0, 0, 4'd0, 0);

    // all-ones kernel, flat 10 field
    for (int a = 0; a < 64; a++) src[a] = 8'd10;
    load_kernel_all(1, 1);
    run_frame(0, 0, 0, 0, 4'd0, 0);

    // positive saturation
    for (int a = 0; a < 64; a++) src[a] = 8'd255;
    load_kernel_all(127, 127);
    run_frame(0, 0, 0, 0, 4'd0, 0);

    // negative clamp
    for (int a = 0; a < 64; a++) src[a] = 8'd5;
    load_kernel_all(0, -1);
    run_frame(0, 0, 0, 0, 4'd0, 0);

    // random kernel; ignored writes (index 9 in IDLE, any write while busy)
    for (int a = 0; a < 64; a++) src[a] = 8'($urandom_range(0, 255));
    for (int t = 0; t < 9; t++) write_k(4'(t), int'($urandom_range(0, 40)) - 20);
    write_k(4'd9, 55);
    run_frame(0, 0, 1, 1, 4'd9, 99);

    // coefficient written alongside start is used by that run
    run_frame(0, 0, 0, 1, 4'd2, -7);

    // start held through DONE gives one run; a later request runs again
    run_frame(1, 0, 0, 0, 4'd0, 0);
    run_frame(0, 0, 0, 0, 4'd0, 0);

    // reset mid-run, cleared kernel, then reload and rerun
    run_frame(0, 100, 0, 0, 4'd0, 0);
    run_frame(0, 0, 0, 0, 4'd0, 0);
    for (int t = 0; t < 9; t++) write_k(4'(t), int'($urandom_range(0, 30)) - 10);
    run_frame(0, 0, 0, 0, 4'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
